// File: rtl/fetch_pkg.sv
// Shared fetch-path types and constants used by the instruction fetch buffer
// and its neighbours.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_buffer.sv
// In-order instruction fetch buffer: issues memory requests for incoming PCs,
// pairs responses with their PCs and hands them to decode; flush drops in-flight work.
module inst_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = fetch_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_valid_i,
    output logic            pc_ready_o,
    input  logic            flush_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_fill_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_discard_cnt;
    logic [XLEN-1:0] r_pc   [DEPTH];
    logic [31:0]     r_inst [DEPTH];
    logic [DEPTH-1:0] r_filled;

    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_fill_idx;
    logic [AW-1:0]    w_rd_idx;
    logic [PW-1:0]    w_occupancy;
    logic [PW-1:0]    w_in_flight;
    logic [PW-1:0]    w_rvalid_ext;
    logic             w_full;
    logic             w_grant;
    logic             w_keep;
    logic             w_drop;
    logic             w_pop;
    logic [DEPTH-1:0] w_filled_next;

    assign w_wr_idx     = r_wr_ptr[AW-1:0];
    assign w_fill_idx   = r_fill_ptr[AW-1:0];
    assign w_rd_idx     = r_rd_ptr[AW-1:0];
    assign w_occupancy  = r_wr_ptr - r_rd_ptr;
    assign w_in_flight  = r_wr_ptr - r_fill_ptr;
    assign w_rvalid_ext = {{(PW-1){1'b0}}, imem_rvalid_i};
    assign w_full       = (w_occupancy == PW'(DEPTH));

    // Full is judged on pre-pop occupancy, so a pop never frees a slot in its own cycle.
    assign imem_req_o  = pc_valid_i & ~w_full & ~flush_i & ~rst;
    assign imem_addr_o = {pc_i[XLEN-1:2], 2'b00};
    assign pc_ready_o  = imem_req_o & imem_gnt_i;
    assign w_grant     = pc_ready_o;

    assign w_keep = imem_rvalid_i & ~flush_i & (r_discard_cnt == '0);
    assign w_drop = imem_rvalid_i & ~flush_i & (r_discard_cnt != '0);

    assign inst_valid_o = (r_rd_ptr != r_fill_ptr) & r_filled[w_rd_idx];
    assign w_pop        = inst_valid_o & inst_ready_i & ~flush_i;
    assign inst_o       = inst_valid_o ? r_inst[w_rd_idx] : INST_NOP;
    assign inst_pc_o    = r_pc[w_rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_fill_ptr    <= '0;
            r_rd_ptr      <= '0;
            r_discard_cnt <= '0;
        end else if (flush_i) begin
            // Everything still owed by memory becomes garbage; a response arriving now is one of them.
            r_rd_ptr      <= r_wr_ptr;
            r_fill_ptr    <= r_wr_ptr;
            r_discard_cnt <= r_discard_cnt + w_in_flight - w_rvalid_ext;
        end else begin
            if (w_grant) r_wr_ptr      <= r_wr_ptr + 1'b1;
            if (w_keep)  r_fill_ptr    <= r_fill_ptr + 1'b1;
            if (w_pop)   r_rd_ptr      <= r_rd_ptr + 1'b1;
            if (w_drop)  r_discard_cnt <= r_discard_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant) r_pc[w_wr_idx]     <= pc_i;
        if (w_keep)  r_inst[w_fill_idx] <= imem_rdata_i;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_filled
            assign w_filled_next[gi] =
                (w_keep  && (w_fill_idx == AW'(gi))) ? 1'b1 :
                (w_grant && (w_wr_idx   == AW'(gi))) ? 1'b0 :
                r_filled[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_filled <= '0;
        else     r_filled <= w_filled_next;
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed and random stimulus for inst_fetch_buffer, checked against a queue-based
// model of granted PCs, owed memory responses and discarded responses.
module tb_inst_fetch_buffer;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    inst_fetch_buffer #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_valid_i   (pc_valid_i),
        .pc_ready_o   (pc_ready_o),
        .flush_i      (flush_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        fetch_entry_t e;
        logic         filled;
    } slot_t;

    typedef struct packed {
        int          due;
        logic [31:0] data;
    } mresp_t;

    slot_t       bq[$];
    mresp_t      mq[$];
    int          stale;
    int          cyc;
    int          n_assert;
    int          n_fail;
    bit          use_fixed;
    logic [31:0] data_ctr;
    logic        obs_valid, obs_grant, obs_req;
    logic [31:0] obs_inst, obs_pc, obs_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, check at +1, update the model, advance to next negedge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic gnt,
                         input logic fl, input logic rdy, input logic mem_go);
        logic        e_full, e_req, e_grant, e_valid, rv, found;
        logic [31:0] rd;
        int          unfilled;
        pc_valid_i   = v;
        pc_i         = pc;
        imem_gnt_i   = gnt;
        flush_i      = fl;
        inst_ready_i = rdy;
        rv = mem_go && (mq.size() > 0) && (mq[0].due <= cyc);
        rd = rv ? mq[0].data : $urandom;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        #1;
        e_full  = (bq.size() == DEPTH);
        e_req   = v & ~e_full & ~fl;
        e_grant = e_req & gnt;
        e_valid = (bq.size() > 0) && bq[0].filled;
        obs_valid = inst_valid_o; obs_grant = pc_ready_o; obs_req = imem_req_o;
        obs_inst  = inst_o;       obs_pc    = inst_pc_o;  obs_addr = imem_addr_o;
        chk("imem_req", imem_req_o, e_req);
        chk("pc_ready", pc_ready_o, e_grant);
        if (e_req) chk("imem_addr", imem_addr_o, {pc[31:2], 2'b00});
        chk("inst_valid", inst_valid_o, e_valid);
        if (e_valid) begin
            chk("inst", inst_o, bq[0].e.inst);
            chk("inst_pc", inst_pc_o, bq[0].e.pc);
        end
        if (fl) begin
            unfilled = 0;
            foreach (bq[i]) if (!bq[i].filled) unfilled++;
            stale = stale + unfilled - (rv ? 1 : 0);
            bq.delete();
        end else begin
            if (rv) begin
                if (stale > 0) stale--;
                else begin
                    found = 1'b0;
                    for (int i = 0; i < bq.size(); i++) begin
                        if (!found && !bq[i].filled) begin
                            bq[i].filled = 1'b1;
                            bq[i].e.inst = rd;
                            found = 1'b1;
                        end
                    end
                end
            end
            if (e_valid && rdy) void'(bq.pop_front());
            if (e_grant) bq.push_back('{e: '{pc: pc, inst: 32'h0}, filled: 1'b0});
        end
        if (rv) void'(mq.pop_front());
        if (e_grant) begin
            mq.push_back('{due: cyc + 1, data: use_fixed ? data_ctr : $urandom});
            if (use_fixed) data_ctr++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && (bq.size() > 0 || mq.size() > 0 || stale > 0); k++)
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("drain_idle", inst_valid_o, 1'b0);
    endtask

    task automatic wait_first_valid(input int max, input logic [31:0] e_pc, input logic [31:0] e_inst);
        bit got = 0;
        for (int k = 0; k < max && !got; k++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
            if (obs_valid) begin
                got = 1;
                chk("first_pc", obs_pc, e_pc);
                chk("first_inst", obs_inst, e_inst);
            end
        end
        chk("first_valid_seen", got, 1'b1);
    endtask

    initial begin
        int          g;
        logic [31:0] p;
        n_assert = 0; n_fail = 0; stale = 0; cyc = 0;
        use_fixed = 1'b1; data_ctr = 32'h0;
        rst = 1'b1; pc_valid_i = 1'b1; pc_i = 32'h0; imem_gnt_i = 1'b1; flush_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; inst_ready_i = 1'b1;
        #2;
        chk("rst_inst_valid", inst_valid_o, 1'b0);
        chk("rst_imem_req", imem_req_o, 1'b0);
        chk("rst_pc_ready", pc_ready_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back fetch with single-cycle memory
        data_ctr = 32'hA0;
        for (int k = 0; k < 5; k++) begin
            cycle(k < 3, 32'(4 * k), 1'b1, 1'b0, 1'b1, 1'b1);
            if (k >= 2) begin
                chk("t1_valid", obs_valid, 1'b1);
                chk("t1_pc", obs_pc, 32'(4 * (k - 2)));
                chk("t1_inst", obs_inst, 32'hA0 + 32'(k - 2));
            end else begin
                chk("t1_idle", obs_valid, 1'b0);
            end
        end
        drain();

        // Full buffer blocks requests until a pop
        g = 0; p = 32'h1000;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, p, 1'b1, 1'b0, 1'b0, 1'b1);
            if (obs_grant) begin g++; p += 4; end
        end
        chk("t2_grants", g, 4);
        chk("t2_req_full", obs_req, 1'b0);
        cycle(1'b1, p, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("t2_pop_cycle_grant", obs_grant, 1'b0);
        cycle(1'b1, p, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t2_after_pop_grant", obs_grant, 1'b1);
        cycle(1'b1, p + 4, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t2_full_again", obs_grant, 1'b0);
        drain();

        // Flush with two requests in flight
        data_ctr = 32'hB0;
        cycle(1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h14, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t3_flush_req", obs_req, 1'b0);
        cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("t3_new_grant", obs_grant, 1'b1);
        wait_first_valid(8, 32'h100, 32'hB2);
        drain();

        // Flush coinciding with a response and a pending pop
        data_ctr = 32'hD0;
        cycle(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h48, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t4_head_in_flush", obs_valid, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
            chk("t4_no_output", obs_valid, 1'b0);
        end
        cycle(1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_first_valid(8, 32'h80, 32'hD3);
        drain();

        // Grant stall holds the PC; address is word-aligned
        data_ctr = 32'hE0;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1);
            chk("t5_stall_ready", obs_grant, 1'b0);
        end
        cycle(1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("t5_grant", obs_grant, 1'b1);
        chk("t5_addr", obs_addr, 32'h20);
        wait_first_valid(8, 32'h22, 32'hE0);
        drain();

        // Asynchronous reset with three buffered entries
        data_ctr = 32'hF0;
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'h300 + 32'(4 * k), 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_buffered", bq.size(), 3);
        pc_valid_i = 1'b1; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", inst_valid_o, 1'b0);
        chk("t6_rst_req", imem_req_o, 1'b0);
        chk("t6_rst_ready", pc_ready_o, 1'b0);
        bq.delete(); mq.delete(); stale = 0;
        @(posedge clk); cyc++; @(negedge clk);
        rst = 1'b0;
        data_ctr = 32'hC0;
        cycle(1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_first_valid(8, 32'h200, 32'hC0);
        drain();

        // Random traffic against the model
        use_fixed = 1'b0;
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 9) < 8, $urandom, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 7);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- Stage directly downstream of the PC generator.
- Takes the PC stream (valid/ready), issues in-order instruction-memory requests, and holds returned instructions with their PCs in a small in-order buffer.
- Presents instruction and PC to decode with a valid/ready handshake.
- On branch redirect (flush), drops all buffered entries and discards responses still in flight.

Parameters:
- DEPTH, 4, buffer entries and maximum in-flight plus buffered requests; power of 2, at least 2.
- XLEN, 32, PC and instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- pc_i  in  XLEN  PC from fetch
- pc_valid_i  in  1  PC valid
- pc_ready_o  out  1  PC accepted this cycle; drives fetch ready
- flush_i  in  1  branch redirect; same signal as fetch branch_taken
- imem_req_o  out  1  memory request
- imem_addr_o  out  XLEN  request address, {pc_i[XLEN-1:2],2'b00}
- imem_gnt_i  in  1  request granted this cycle
- imem_rvalid_i  in  1  response valid; in order, earliest 1 cycle after grant
- imem_rdata_i  in  32  response instruction word
- inst_valid_o  out  1  head entry valid to decode
- inst_ready_i  in  1  decode accepts
- inst_o  out  32  instruction
- inst_pc_o  out  XLEN  PC of instruction

Behaviour:
- State: entry array {pc, data, filled}.
  - wr_ptr: advances on grant.
  - fill_ptr: advances on a kept response.
  - rd_ptr: advances on pop.
  - Pointers are log2(DEPTH)+1 bits, so wrap is implicit.
  - discard_cnt: 0..DEPTH.
- occupancy = wr_ptr - rd_ptr; full = (occupancy == DEPTH).
- imem_req_o = pc_valid_i & ~full & ~flush_i & ~rst; combinational.
- pc_ready_o = imem_req_o & imem_gnt_i. A PC transfers only on grant; the PC is stored in entry[wr_ptr] with filled=0.
- Response (imem_rvalid_i):
  - If discard_cnt > 0: decrement discard_cnt and drop the data.
  - Otherwise: write data to entry[fill_ptr], set filled, and increment fill_ptr.
- inst_valid_o = (rd_ptr != fill_ptr), read from registered state only.
  - inst_o / inst_pc_o come from entry[rd_ptr].
  - Latency: grant in cycle N, rvalid in N+1, inst_valid_o in N+2.
- Pop on inst_valid_o & inst_ready_i & ~flush_i.
- Throughput: 1 instruction per cycle sustained with 1-cycle memory and DEPTH >= 3.
- Flush (flush_i=1):
  - Next state: rd_ptr = fill_ptr = wr_ptr.
  - discard_cnt_next = discard_cnt + (wr_ptr - fill_ptr) - (rvalid this cycle ? 1 : 0).
  - No request, no grant, no pop in the flush cycle.
  - A rvalid in the flush cycle is dropped.
  - Decode must also ignore inst_valid_o in the flush cycle.
- After flush:
  - New PCs may be requested on the next cycle while discard_cnt > 0.
  - Discards are drained before any new response is kept; in-order responses guarantee this.
- Full: no request until a pop. Pop and grant in the same cycle while full: grant is blocked that cycle because full is pre-pop state.
- Empty: inst_valid_o=0; inst_o/inst_pc_o are don't-care.
- rvalid with no outstanding request and discard_cnt=0 is illegal; the verification checker flags it.
- Reset (any time, including mid-transfer):
  - All pointers and discard_cnt go to 0; filled bits are cleared.
  - inst_valid_o=0, imem_req_o=0, pc_ready_o=0.
  - In-flight memory transactions are the memory's responsibility; the memory is reset together with this block.

Decomposition:
- Shared package fetch_pkg:
  - XLEN.
  - fetch_entry_t {pc, inst}.
  - INST_NOP = 32'h0000_0013.
- Storage, pointers and discard logic stay flat in this module; no sub-module.

Test Plan:
- Reset, then pc 0x0, 0x4, 0x8 with gnt=1 and 1-cycle rdata 0xA0, 0xA1, 0xA2, ready=1 -> inst_valid_o from cycle 2, pairs (0x0,A0), (0x4,A1), (0x8,A2) on consecutive cycles.
- inst_ready_i=0, DEPTH=4, continuous PCs -> 4 grants, then imem_req_o=0 and pc_ready_o=0; one pop -> exactly one more grant next cycle.
- 2 requests in flight (pc 0x10, 0x14), flush_i with pc 0x100 next -> both old responses dropped, discard_cnt 2→0, first output is (0x100, its rdata).
- Flush in the same cycle as rvalid and a pending pop -> no pop, that response dropped, discard_cnt = in-flight - 1, no output until a new PC completes.
- imem_gnt_i=0 for 3 cycles with pc_valid_i=1 -> pc_ready_o=0 and pc held; gnt=1 -> single transfer, addr = pc & ~3 (pc 0x22 -> 0x20).
- rst asserted asynchronously mid-stream with 3 entries buffered -> inst_valid_o=0 immediately; after release the first output is the first new PC.
